// File: rtl/ping_ranger_ctrl.sv
// ping_ranger_ctrl
// Measurement sequencer for a trigger/echo ultrasonic ping sensor. It issues
// the trigger pulse, synchronises and edge-detects the echo, runs a 1 us tick,
// drives the external 16-bit echo-width counter (clear + count enable) and
// latches that counter's value as the measured distance in microseconds.
//
// Ports:
//   clk         system clock
//   reset       synchronous, active-high; all state cleared on the next edge
//   start_i     request one measurement (level, sampled in IDLE)
//   auto_i      free-run mode, behaves as a continuous start
//   echo_i      asynchronous sensor echo
//   cntr_q_i    echo-width counter output
//   trig_o      sensor trigger
//   cntr_rst_o  counter synchronous clear
//   cntr_ce_o   counter enable, one-cycle pulses (one per echo-high tick)
//   dist_us_o   last echo width in us, 16'hFFFF on timeout
//   valid_o     one-cycle pulse when dist_us_o updates
//   timeout_o   last measurement timed out; held until the next valid
//   busy_o      low only while idle
module ping_ranger_ctrl #(
    parameter int unsigned TICK_DIV   = 50,
    parameter int unsigned TRIG_US    = 10,
    parameter int unsigned TIMEOUT_US = 30000,
    parameter int unsigned HOLDOFF_US = 60000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start_i,
    input  logic        auto_i,
    input  logic        echo_i,
    input  logic [15:0] cntr_q_i,
    output logic        trig_o,
    output logic        cntr_rst_o,
    output logic        cntr_ce_o,
    output logic [15:0] dist_us_o,
    output logic        valid_o,
    output logic        timeout_o,
    output logic        busy_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_TRIG,
        S_WAIT_RISE,
        S_MEASURE,
        S_DONE,
        S_HOLDOFF
    } state_t;

    localparam logic [15:0] TICK_LAST    = 16'(TICK_DIV - 1);
    localparam logic [15:0] TRIG_LAST    = 16'(TRIG_US - 1);
    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_US - 1);
    localparam logic [15:0] HOLDOFF_LAST = 16'(HOLDOFF_US - 1);

    state_t      state_q, state_d;
    logic [15:0] div_q, div_d;
    logic [15:0] tmr_q, tmr_d;
    logic [15:0] dist_q, dist_d;
    logic        timeout_q, timeout_d;
    logic        echoMeta_q, echoSync_q, echoPrev_q;
    logic        tick, rise, fall, abortTimeout;

    assign tick = (div_q == TICK_LAST);
    assign rise = echoSync_q & ~echoPrev_q;
    assign fall = ~echoSync_q & echoPrev_q;

    // Next-state logic. abortTimeout marks a transition into DONE caused by the
    // tick timer expiring rather than by an echo edge; a fall in the same cycle
    // wins because it is tested first.
    always_comb begin
        state_d      = state_q;
        abortTimeout = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start_i || auto_i) state_d = S_TRIG;
            end
            S_TRIG: begin
                if (tick && tmr_q == TRIG_LAST) state_d = S_WAIT_RISE;
            end
            S_WAIT_RISE: begin
                if (rise) begin
                    state_d = S_MEASURE;
                end else if (tick && tmr_q == TIMEOUT_LAST) begin
                    state_d      = S_DONE;
                    abortTimeout = 1'b1;
                end
            end
            S_MEASURE: begin
                if (fall) begin
                    state_d = S_DONE;
                end else if (tick && tmr_q == TIMEOUT_LAST) begin
                    state_d      = S_DONE;
                    abortTimeout = 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_HOLDOFF;
            end
            S_HOLDOFF: begin
                if (tick && tmr_q == HOLDOFF_LAST) state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Tick divider, tick timer and result capture. Entry to MEASURE preloads
    // the divider with 1 because the rise-detect cycle already belongs to the
    // echo-high time. The result is loaded on the edge into DONE so that it is
    // on dist_us_o during the valid cycle; the counter is already settled then
    // since no enable is issued in the fall cycle.
    always_comb begin
        div_d     = tick ? 16'd0 : div_q + 16'd1;
        tmr_d     = tick ? tmr_q + 16'd1 : tmr_q;
        dist_d    = dist_q;
        timeout_d = timeout_q;
        if (state_d != state_q) begin
            div_d = (state_d == S_MEASURE) ? 16'd1 : 16'd0;
            tmr_d = 16'd0;
        end
        if (state_d == S_DONE) begin
            dist_d    = abortTimeout ? 16'hFFFF : cntr_q_i;
            timeout_d = abortTimeout;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            div_q      <= 16'd0;
            tmr_q      <= 16'd0;
            dist_q     <= 16'd0;
            timeout_q  <= 1'b0;
            echoMeta_q <= 1'b0;
            echoSync_q <= 1'b0;
            echoPrev_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            div_q      <= div_d;
            tmr_q      <= tmr_d;
            dist_q     <= dist_d;
            timeout_q  <= timeout_d;
            echoMeta_q <= echo_i;
            echoSync_q <= echoMeta_q;
            echoPrev_q <= echoSync_q;
        end
    end

    // All outputs come from flops only: no input reaches them combinationally.
    assign trig_o     = (state_q == S_TRIG);
    assign cntr_rst_o = (state_q == S_TRIG);
    assign cntr_ce_o  = (state_q == S_MEASURE) && tick && !fall;
    assign valid_o    = (state_q == S_DONE);
    assign busy_o     = (state_q != S_IDLE);
    assign dist_us_o  = dist_q;
    assign timeout_o  = timeout_q;

endmodule

// File: tb/tb_ping_ranger_ctrl.sv
// tb_ping_ranger_ctrl
// Self-checking bench for ping_ranger_ctrl. Models the external 16-bit
// echo-width counter, drives echo pulses of chosen and random widths and
// compares results against a width-based reference model.
module tb_ping_ranger_ctrl;

    localparam int TICK_DIV     = 4;
    localparam int TRIG_US      = 10;
    localparam int TIMEOUT_US   = 100;
    localparam int HOLDOFF_US   = 20;
    localparam int TRIG_CLKS    = TRIG_US * TICK_DIV;
    localparam int TIMEOUT_CLKS = TIMEOUT_US * TICK_DIV;
    localparam int HOLDOFF_CLKS = HOLDOFF_US * TICK_DIV;
    localparam int NO_RESULT    = 32'hFFFF;

    logic        clk       = 1'b0;
    logic        reset     = 1'b1;
    logic        start     = 1'b0;
    logic        autoMode  = 1'b0;
    logic        echo      = 1'b0;
    logic [15:0] cntrQ     = 16'd0;
    logic        trig, cntrRst, cntrCe, valid, timeoutFlag, busy;
    logic [15:0] distUs;

    int checks   = 0;
    int failures = 0;

    int          cycle = 0;
    int          trigCount, rstCount, ceCount, validCount;
    int          validCycle, trigFallCycle, idleCycle;
    bit          trigFell, awaitIdle, idleSeen, prevTrig;
    logic [15:0] lastDist;
    logic        lastTimeout;

    ping_ranger_ctrl #(
        .TICK_DIV  (TICK_DIV),
        .TRIG_US   (TRIG_US),
        .TIMEOUT_US(TIMEOUT_US),
        .HOLDOFF_US(HOLDOFF_US)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start_i   (start),
        .auto_i    (autoMode),
        .echo_i    (echo),
        .cntr_q_i  (cntrQ),
        .trig_o    (trig),
        .cntr_rst_o(cntrRst),
        .cntr_ce_o (cntrCe),
        .dist_us_o (distUs),
        .valid_o   (valid),
        .timeout_o (timeoutFlag),
        .busy_o    (busy)
    );

    always #5 clk = ~clk;

    // External echo-width counter: synchronous clear, count on enable.
    always @(posedge clk) begin
        if (cntrRst) cntrQ <= 16'd0;
        else if (cntrCe) cntrQ <= cntrQ + 16'd1;
    end

    // Monitor on the falling edge: counts output activity and timestamps the
    // trigger fall, the valid pulse and the return to idle after it.
    always @(negedge clk) begin
        if (trig) trigCount++;
        if (prevTrig && !trig) begin
            trigFallCycle = cycle;
            trigFell      = 1'b1;
        end
        prevTrig = trig;
        if (cntrRst) rstCount++;
        if (cntrCe) ceCount++;
        if (valid) begin
            validCount++;
            lastDist    = distUs;
            lastTimeout = timeoutFlag;
            validCycle  = cycle;
            awaitIdle   = 1'b1;
        end else if (awaitIdle && !busy) begin
            idleCycle = cycle;
            idleSeen  = 1'b1;
            awaitIdle = 1'b0;
        end
        cycle++;
    end

    // Every comparison of the bench goes through here.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
        end
    endtask

    // Reference model: one count per whole tick of echo-high time; an echo
    // lasting the full timeout window or longer is reported as a timeout.
    function automatic int modelDist(input int width);
        return (width >= TIMEOUT_CLKS) ? NO_RESULT : width / TICK_DIV;
    endfunction

    task automatic clearCounters();
        trigCount  = 0;
        rstCount   = 0;
        ceCount    = 0;
        validCount = 0;
        trigFell   = 1'b0;
        awaitIdle  = 1'b0;
        idleSeen   = 1'b0;
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic pulseStart();
        start = 1'b1;
        nextCycle();
        start = 1'b0;
    endtask

    task automatic waitTrigFall(input string tag);
        for (int i = 0; i < TRIG_CLKS + 2000; i++) begin
            nextCycle();
            if (trigFell) break;
        end
        checkOutput($sformatf("%s_trigFall", tag), 32'(trigFell), 32'd1);
    endtask

    // Holds echo high for exactly 'width' sampling edges after 'riseDelay'
    // cycles; optionally pokes start while the echo is high.
    task automatic applyStimulus(input int riseDelay, input int width, input bit pokeStart);
        for (int i = 0; i < riseDelay; i++) nextCycle();
        echo = 1'b1;
        for (int i = 0; i < width; i++) begin
            start = pokeStart && (i == width / 2);
            nextCycle();
        end
        start = 1'b0;
        echo  = 1'b0;
    endtask

    task automatic waitResult(input string tag);
        for (int i = 0; i < 3000; i++) begin
            if (validCount > 0 && idleSeen) break;
            nextCycle();
        end
        checkOutput($sformatf("%s_validCount", tag), 32'(validCount), 32'd1);
        checkOutput($sformatf("%s_idleSeen", tag), 32'(idleSeen), 32'd1);
    endtask

    task automatic waitIdle(input string tag);
        for (int i = 0; i < 3000; i++) begin
            if (!busy) break;
            nextCycle();
        end
        checkOutput($sformatf("%s_idle", tag), 32'(busy), 32'd0);
    endtask

    task automatic measureOnce(input string tag, input int riseDelay, input int width,
                               input bit doStart, input bit pokeStart);
        int expDist;
        expDist = modelDist(width);
        clearCounters();
        if (doStart) pulseStart();
        waitTrigFall(tag);
        applyStimulus(riseDelay, width, pokeStart);
        waitResult(tag);
        checkOutput($sformatf("%s_dist", tag), 32'(lastDist), 32'(expDist));
        checkOutput($sformatf("%s_timeout", tag), 32'(lastTimeout),
                    (expDist == NO_RESULT) ? 32'd1 : 32'd0);
        checkOutput($sformatf("%s_trigWidth", tag), 32'(trigCount), 32'(TRIG_CLKS));
        if (expDist != NO_RESULT)
            checkOutput($sformatf("%s_ceCount", tag), 32'(ceCount), 32'(expDist));
    endtask

    // Watchdog so the run always ends even if a wait misbehaves.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: observed no finish, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int busyCount;
        int autoWidths [3];
        clearCounters();

        // Reset state while reset is held and after release.
        repeat (3) nextCycle();
        checkOutput("rst_trig", 32'(trig), 32'd0);
        checkOutput("rst_cntrRst", 32'(cntrRst), 32'd0);
        checkOutput("rst_cntrCe", 32'(cntrCe), 32'd0);
        checkOutput("rst_dist", 32'(distUs), 32'd0);
        checkOutput("rst_valid", 32'(valid), 32'd0);
        checkOutput("rst_timeout", 32'(timeoutFlag), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        reset = 1'b0;
        repeat (3) nextCycle();
        checkOutput("idle_busy", 32'(busy), 32'd0);

        // Normal measurement with exact trigger, clear and holdoff timing.
        $display("[TB] normal measurement");
        measureOnce("normal", 20, 148, 1'b1, 1'b0);
        checkOutput("normal_rstWidth", 32'(rstCount), 32'(TRIG_CLKS));
        checkOutput("normal_holdoff", 32'(idleCycle - validCycle - 1), 32'(HOLDOFF_CLKS));

        // Width boundaries, including fall coinciding with the timeout tick.
        $display("[TB] boundary widths");
        measureOnce("w147", 20, 147, 1'b1, 1'b0);
        measureOnce("w4", 5, 4, 1'b1, 1'b0);
        measureOnce("w3", 5, 3, 1'b1, 1'b0);
        measureOnce("w399", 5, TIMEOUT_CLKS - 1, 1'b1, 1'b0);
        measureOnce("w400", 5, TIMEOUT_CLKS, 1'b1, 1'b0);

        // No echo: timeout after the full wait window; extra starts ignored.
        $display("[TB] no echo");
        clearCounters();
        pulseStart();
        waitTrigFall("noEcho");
        pulseStart();
        for (int i = 0; i < 2000; i++) begin
            if (validCount > 0) break;
            nextCycle();
        end
        checkOutput("noEcho_validCount", 32'(validCount), 32'd1);
        pulseStart();
        waitIdle("noEcho");
        checkOutput("noEcho_latency", 32'(validCycle - trigFallCycle), 32'(TIMEOUT_CLKS));
        checkOutput("noEcho_dist", 32'(lastDist), 32'hFFFF);
        checkOutput("noEcho_timeout", 32'(lastTimeout), 32'd1);
        checkOutput("noEcho_trigWidth", 32'(trigCount), 32'(TRIG_CLKS));
        busyCount = 0;
        for (int i = 0; i < 30; i++) begin
            nextCycle();
            if (busy) busyCount++;
        end
        checkOutput("noEcho_noQueue", 32'(busyCount), 32'd0);

        // Echo already high before the trigger: rise is missed.
        $display("[TB] stuck echo");
        echo = 1'b1;
        clearCounters();
        pulseStart();
        waitResult("stuck");
        echo = 1'b0;
        checkOutput("stuck_dist", 32'(lastDist), 32'hFFFF);
        checkOutput("stuck_timeout", 32'(lastTimeout), 32'd1);
        checkOutput("stuck_ceCount", 32'(ceCount), 32'd0);

        // Randomised delays and widths, some past the timeout window.
        $display("[TB] random measurements");
        for (int n = 0; n < 6; n++) begin
            measureOnce($sformatf("rand%0d", n), int'($urandom_range(300, 1)),
                        int'($urandom_range(450, 1)), 1'b1, 1'b0);
        end

        // Free-running mode with start pokes while busy.
        $display("[TB] auto mode");
        autoWidths[0] = 10 * TICK_DIV;
        autoWidths[1] = 50 * TICK_DIV;
        autoWidths[2] = 99 * TICK_DIV;
        autoMode = 1'b1;
        for (int n = 0; n < 3; n++) begin
            measureOnce($sformatf("auto%0d", n), 10 + n * 7, autoWidths[n], 1'b0, 1'b1);
        end
        autoMode = 1'b0;
        waitIdle("autoEnd");

        // Reset in the middle of a measurement.
        $display("[TB] reset mid-measure");
        clearCounters();
        pulseStart();
        waitTrigFall("midRst");
        for (int i = 0; i < 10; i++) nextCycle();
        echo = 1'b1;
        for (int i = 0; i < 30; i++) nextCycle();
        clearCounters();
        reset = 1'b1;
        nextCycle();
        checkOutput("midRst_trig", 32'(trig), 32'd0);
        checkOutput("midRst_busy", 32'(busy), 32'd0);
        checkOutput("midRst_valid", 32'(valid), 32'd0);
        checkOutput("midRst_dist", 32'(distUs), 32'd0);
        reset = 1'b0;
        echo  = 1'b0;
        for (int i = 0; i < 100; i++) nextCycle();
        checkOutput("midRst_noValid", 32'(validCount), 32'd0);
        measureOnce("afterRst", 15, 100, 1'b1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule

// File: doc/ping_ranger_ctrl.md
Name: ping_ranger_ctrl

Overview:
- Measurement sequencer for an ultrasonic ping sensor (trigger/echo type).
- Issues the trigger pulse, synchronises and edge-detects the echo input, and generates a 1 us tick.
- Drives the clear and count-enable of the external 16-bit echo-width counter, then latches that counter's output as the result.
- Sits between the sensor pins and the counter. The result feeds the display/distance logic.

Parameters:
- TICK_DIV, 50: clk cycles per 1 us tick (>=2; 50 MHz clock).
- TRIG_US, 10: trigger pulse width in ticks.
- TIMEOUT_US, 30000: max ticks in WAIT_RISE or MEASURE before abort (<=65534).
- HOLDOFF_US, 60000: dead time in ticks after each measurement, before returning to IDLE.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high; all state cleared on the next clk edge
- start  in  1  request one measurement (level sampled in IDLE)
- auto  in  1  free-run: treated as a continuous start
- echo  in  1  asynchronous sensor echo
- cntr_q  in  16  echo-width counter output
- trig  out  1  sensor trigger, registered
- cntr_rst  out  1  counter synchronous clear
- cntr_ce  out  1  counter enable, one-cycle pulses
- dist_us  out  16  last echo width in us; 16'hFFFF on timeout
- valid  out  1  one-cycle pulse when dist_us updates
- timeout  out  1  1 if the last measurement timed out; held until the next valid
- busy  out  1  0 only in IDLE

Behaviour:
- Clock and reset: clk only. reset is synchronous, active-high.
- Reset values: state=IDLE, trig=0, cntr_rst=0, cntr_ce=0, dist_us=0, valid=0, timeout=0, busy=0. The echo synchroniser flops and the prev-echo flop clear to 0.
- Reset mid-operation aborts immediately. trig drops on the same edge and no valid is issued.
- Echo path: 2-flop synchroniser, then edge detect against a prev flop.
  - rise = sync & ~prev; fall = ~sync & prev.
  - Echo-to-detect latency is 2 clk.
- Tick divider:
  - 16-bit div counts 0..TICK_DIV-1; tick=1 when div==TICK_DIV-1, then wraps to 0.
  - On every state change div loads 0, except entry to MEASURE, which loads 1 (accounts for the rise-detect cycle).
- Tick timer: tmr (16 bit) counts ticks and clears on every state change.
- States:
  - IDLE: if start|auto, go to TRIG.
  - TRIG: trig=1 and cntr_rst=1. When tmr==TRIG_US-1 and tick, go to WAIT_RISE. Trigger width is exactly TRIG_US*TICK_DIV clk.
  - WAIT_RISE: on rise, go to MEASURE. Else if tmr==TIMEOUT_US-1 and tick, go to DONE with the timeout flag set internally. Echo already high on entry (rise missed, e.g. during TRIG) produces a timeout.
  - MEASURE: cntr_ce = tick & ~fall.
    - On fall, go to DONE.
    - Else if tmr==TIMEOUT_US-1 and tick, go to DONE with the timeout flag.
    - Fall and timeout in the same cycle: fall wins.
  - DONE (1 cycle): valid=1.
    - dist_us = timeout ? 16'hFFFF : cntr_q. cntr_q is stable here: the counter has 1-cycle latency and no ce is issued in the fall cycle.
    - timeout output = the flag.
    - Next state HOLDOFF.
  - HOLDOFF: when tmr==HOLDOFF_US-1 and tick, go to IDLE.
- Result rule: for H synchronised echo-high clk cycles, dist_us = floor(H/TICK_DIV).
- start or auto outside IDLE is ignored. No queuing.
- cntr_ce never asserts outside MEASURE, and cntr_rst never asserts outside TRIG. The counter therefore cannot wrap, given TIMEOUT_US<=65534.
- Outputs are registered. busy, trig, cntr_rst and valid are decoded from the state register, with no combinational path from inputs.

Test Plan:
(Bench parameters: TICK_DIV=4, TRIG_US=10, TIMEOUT_US=100, HOLDOFF_US=20; bench models cntr16ce.)
- Normal: 1-cycle start; echo rises 20 clk after trig falls and stays high 148 clk -> trig high exactly 40 clk; cntr_rst high the same 40 clk; exactly 37 cntr_ce pulses; one valid pulse; dist_us=37; timeout=0; busy back to 0 exactly 80 clk after DONE.
- Boundary width: echo high 147 clk -> dist_us=36; echo high 4 clk -> dist_us=1; echo high 3 clk -> dist_us=0.
- No echo: start, echo held 0 -> valid exactly 400 clk after WAIT_RISE entry; dist_us=16'hFFFF; timeout=1.
- Stuck echo: echo held high through TRIG and WAIT_RISE -> dist_us=16'hFFFF; timeout=1; zero cntr_ce pulses.
- Auto mode: auto=1 with 3 echoes of 10, 50, 99 us -> three valid pulses with dist_us 10, 50, 99; start pulses during busy have no effect.
- Reset mid-MEASURE: assert reset 1 cycle -> next edge: trig=0, busy=0, valid=0, dist_us=0; a subsequent start measures correctly.
